univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, the multi-bit clocked successor to the single-bit D latch. It provides hold, serial shift, rotate, arithmetic shift, parallel load and clear.
Operations run either single-step, one per enabled clock, or as a counted burst under a start/busy/done handshake.
It is the general-purpose storage and serialisation element for the flop/latch library and for later serial interface blocks.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst count; max burst = 2^CNT_W-1 operations

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all state
enable  input  1  clock enable; 0 freezes register, FSM and counter
mode  input  3  operation select (see Behaviour)
start  input  1  begin burst of count operations using mode
count  input  CNT_W  number of burst operations
d  input  WIDTH  parallel load data
sin_r  input  1  serial in for shift right (enters at MSB)
sin_l  input  1  serial in for shift left (enters at LSB)
q  output  WIDTH  register contents
sout_r  output  1  q[0], combinational from register
sout_l  output  1  q[WIDTH-1], combinational from register
busy  output  1  burst in progress
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk. It overrides everything: q=0, busy=0, done=0, remaining count=0, FSM=IDLE.
- Reset mid-burst aborts the burst. done does not pulse.
- Mode encoding, next q:
  - 000 HOLD: q
  - 001 SHR: {sin_r, q[WIDTH-1:1]}
  - 010 SHL: {q[WIDTH-2:0], sin_l}
  - 011 LOAD: d
  - 100 ROR: {q[0], q[WIDTH-1:1]}
  - 101 ROL: {q[WIDTH-2:0], q[WIDTH-1]}
  - 110 ASR: {q[WIDTH-1], q[WIDTH-1:1]}
  - 111 CLR: 0
- sin_r, sin_l and d are sampled live at each operating edge, including during a burst.
- FSM states: IDLE, RUN.
- IDLE, enable=1, start=0: apply mode at this edge. q updates one cycle after the inputs are sampled (latency 1).
- IDLE, enable=1, start=1, count!=0:
  - No operation at this edge.
  - Latch mode into op_r and count into rem.
  - busy=1, go to RUN.
- IDLE, enable=1, start=1, count=0: no operation, stay in IDLE, done=1 for one cycle.
- RUN, enable=1:
  - Apply op_r and decrement rem. Live mode and start are ignored.
  - When rem goes 1->0: busy=0 and done=1 at the same edge, go to IDLE.
  - An uninterrupted N-operation burst holds busy high for exactly N cycles.
- RUN, enable=0: full freeze (q, rem, state). busy stays 1.
- enable=0 in IDLE: q held. start is ignored and not remembered.
- done is high only for the single cycle after the completing edge and is cleared on the next edge.
- A start on the cycle done is high is accepted normally, giving back-to-back bursts.
- Wrap-around: count=2^CNT_W-1 runs the full length. rem never underflows.

Decomposition:
- Package shift_reg_pkg:
  - mode localparams MODE_HOLD..MODE_CLR (3-bit)
  - FSM state encoding ST_IDLE/ST_RUN
- Sub-module shift_op_unit: combinational next-value function (q, mode, d, sin_r, sin_l -> q_next), parametrised by WIDTH.
- univ_shift_reg holds the register, FSM and counter.

Test Plan:
- Reset/load: reset=1 with d=8'hA5, mode=LOAD, then reset=0 and one LOAD -> q=00 during reset, then q=A5. Apply reset mid-burst -> q=00, busy=0, no done.
- Single-step: q=8'h81, then one cycle each of SHR sin_r=0, SHL sin_l=1, ROR, ROL -> q=40, 81, C0, 81. ASR on 8'h80 -> C0.
- Burst: q=8'h01, start with mode=ROL, count=3 -> busy high 3 cycles, q=02, 04, 08. done pulses on the cycle q=08, then busy=0.
- Pause: during the same burst, drop enable for 2 cycles after the first op -> q holds 02, busy stays 1. Completion is delayed 2 cycles and the final q=08.
- Edge counts: start with count=0 -> done pulse, q unchanged, busy never high. start with count=15 -> exactly 15 ops. A new start on the done cycle is accepted. A start while busy is ignored.
- Serial stream: SHL burst of 8 with sin_l pattern 1,0,1,1,0,0,1,0 -> q=8'hB2. sout_l tracks q[7] every cycle.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation codes and
// burst-control FSM state encoding.
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_op_unit.sv
// Combinational next-value function of the shift register for one operation.
module shift_op_unit
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q_next
);

    // Select the next register value for the requested operation
    always_comb begin
        q_next = q;
        case (mode)
            MODE_HOLD: q_next = q;
            MODE_SHR:  q_next = {sin_r, q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], sin_l};
            MODE_LOAD: q_next = d;
            MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
            MODE_CLR:  q_next = {WIDTH{1'b0}};
            default:   q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operation and counted bursts
// under a start/busy/done handshake.
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] REM_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] REM_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [2:0]       op_r;
    logic [2:0]       op_sel_s;
    logic [CNT_W-1:0] rem_r;
    logic             latch_s;
    logic             done_next_s;
    logic             busy_r;
    logic             done_r;

    // Non-operating edges select HOLD, so the register always takes q_next_s
    shift_op_unit #(.WIDTH(WIDTH)) u_op (
        .q      (q_r),
        .mode   (op_sel_s),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q_next (q_next_s)
    );

    // State register plus datapath, counter and handshake flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            q_r     <= {WIDTH{1'b0}};
            op_r    <= MODE_HOLD;
            rem_r   <= REM_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_state_s;
            q_r     <= q_next_s;
            busy_r  <= (next_state_s == ST_RUN);
            done_r  <= done_next_s;
            if (latch_s) begin
                op_r  <= mode;
                rem_r <= count;
            end else if (state_r == ST_RUN && enable) begin
                rem_r <= rem_r - REM_ONE;
            end else begin
                rem_r <= rem_r;
            end
        end
    end

    // Next-state logic for the burst controller
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable && start && count != REM_ZERO) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable && rem_r == REM_ONE) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Per-state operation select, burst latch and completion strobe
    always_comb begin
        op_sel_s    = MODE_HOLD;
        latch_s     = 1'b0;
        done_next_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable && start) begin
                    if (count == REM_ZERO) begin
                        done_next_s = 1'b1;
                    end else begin
                        latch_s = 1'b1;
                    end
                end else if (enable) begin
                    op_sel_s = mode;
                end else begin
                    op_sel_s = MODE_HOLD;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    op_sel_s    = op_r;
                    done_next_s = (rem_r == REM_ONE);
                end else begin
                    op_sel_s = MODE_HOLD;
                end
            end
            default: op_sel_s = MODE_HOLD;
        endcase
    end

    assign q      = q_r;
    assign sout_r = q_r[0];
    assign sout_l = q_r[WIDTH-1];
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, CNT_W=4).
module tb_univ_shift_reg;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [2:0] mode;
    logic       start;
    logic [3:0] count;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .mode   (mode),
        .start  (start),
        .count  (count),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        chk({tag, ".q"}, {24'd0, q}, {24'd0, eq});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    endtask

    task automatic load(input logic [7:0] v);
        start = 1'b0; enable = 1'b1; mode = 3'b011; d = v;
        tick();
        chk("load", {24'd0, q}, {24'd0, v});
    endtask

    logic [7:0] pat;
    logic [7:0] expq;

    initial begin
        reset = 1'b1; enable = 1'b1; mode = 3'b011; start = 1'b0;
        count = 4'd0; d = 8'hA5; sin_r = 1'b0; sin_l = 1'b0;

        // Reset then load
        tick(); tick();
        chk_state("reset", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk("first_load", {24'd0, q}, 32'h0000_00A5);

        // Single-step operations
        load(8'h81);
        mode = 3'b001; sin_r = 1'b0; tick(); chk("shr", {24'd0, q}, 32'h40);
        mode = 3'b010; sin_l = 1'b1; tick(); chk("shl", {24'd0, q}, 32'h81);
        mode = 3'b100; tick(); chk("ror", {24'd0, q}, 32'hC0);
        chk("sout_r", {31'd0, sout_r}, 32'd0);
        chk("sout_l", {31'd0, sout_l}, 32'd1);
        mode = 3'b101; tick(); chk("rol", {24'd0, q}, 32'h81);
        load(8'h80);
        mode = 3'b110; tick(); chk("asr", {24'd0, q}, 32'hC0);
        mode = 3'b000; tick(); chk("hold", {24'd0, q}, 32'hC0);
        mode = 3'b111; tick(); chk("clr", {24'd0, q}, 32'h00);
        enable = 1'b0; mode = 3'b011; d = 8'hFF; start = 1'b1; count = 4'd3;
        tick(); chk_state("en0_idle", 8'h00, 1'b0, 1'b0);
        start = 1'b0; enable = 1'b1; mode = 3'b000;
        tick(); chk_state("en0_forgot", 8'h00, 1'b0, 1'b0);

        // Burst of three ROL; live mode/d ignored while running
        load(8'h01);
        mode = 3'b101; start = 1'b1; count = 4'd3;
        tick(); chk_state("b_start", 8'h01, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b011; d = 8'hFF;
        tick(); chk_state("b_op1", 8'h02, 1'b1, 1'b0);
        tick(); chk_state("b_op2", 8'h04, 1'b1, 1'b0);
        tick(); chk_state("b_op3", 8'h08, 1'b0, 1'b1);
        mode = 3'b000;
        tick(); chk_state("b_after", 8'h08, 1'b0, 1'b0);

        // Same burst paused for two cycles after the first op
        load(8'h01);
        mode = 3'b101; start = 1'b1; count = 4'd3;
        tick(); start = 1'b0; mode = 3'b000;
        tick(); chk_state("p_op1", 8'h02, 1'b1, 1'b0);
        enable = 1'b0;
        tick(); chk_state("p_frz1", 8'h02, 1'b1, 1'b0);
        tick(); chk_state("p_frz2", 8'h02, 1'b1, 1'b0);
        enable = 1'b1;
        tick(); chk_state("p_op2", 8'h04, 1'b1, 1'b0);
        tick(); chk_state("p_op3", 8'h08, 1'b0, 1'b1);

        // Reset mid-burst aborts without done
        load(8'h01);
        mode = 3'b101; start = 1'b1; count = 4'd5;
        tick(); start = 1'b0;
        tick(); chk("r_op1", {24'd0, q}, 32'h02);
        reset = 1'b1;
        tick(); chk_state("r_abort", 8'h00, 1'b0, 1'b0);
        reset = 1'b0; mode = 3'b000;
        tick(); chk_state("r_after", 8'h00, 1'b0, 1'b0);

        // count = 0: done pulse only
        load(8'h5A);
        mode = 3'b101; start = 1'b1; count = 4'd0;
        tick(); chk_state("c0", 8'h5A, 1'b0, 1'b1);
        start = 1'b0; mode = 3'b000;
        tick(); chk_state("c0_after", 8'h5A, 1'b0, 1'b0);

        // count = 15: 01 rotated left 15 times gives 80
        load(8'h01);
        mode = 3'b101; start = 1'b1; count = 4'd15;
        tick(); start = 1'b0; mode = 3'b000;
        chk("c15_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("c15_run", {30'd0, busy, done}, 32'd2);
        end
        tick(); chk_state("c15_end", 8'h80, 1'b0, 1'b1);

        // Back-to-back start accepted on the done cycle
        mode = 3'b100; start = 1'b1; count = 4'd2;
        tick(); chk_state("bb_start", 8'h80, 1'b1, 1'b0);
        start = 1'b0; mode = 3'b000;
        tick(); chk_state("bb_op1", 8'h40, 1'b1, 1'b0);
        tick(); chk_state("bb_op2", 8'h20, 1'b0, 1'b1);

        // Start while busy is ignored
        load(8'h01);
        mode = 3'b101; start = 1'b1; count = 4'd2;
        tick(); mode = 3'b111; count = 4'd5;
        tick(); chk_state("sb_op1", 8'h02, 1'b1, 1'b0);
        start = 1'b0;
        tick(); chk_state("sb_op2", 8'h04, 1'b0, 1'b1);
        mode = 3'b000;
        tick(); chk_state("sb_after", 8'h04, 1'b0, 1'b0);

        // Serial stream: SHL burst of 8 with pattern 1,0,1,1,0,0,1,0
        mode = 3'b111; tick();
        mode = 3'b010; start = 1'b1; count = 4'd8;
        tick(); start = 1'b0; mode = 3'b000;
        pat  = 8'b1011_0010;
        expq = 8'h00;
        for (int i = 0; i < 8; i++) begin
            sin_l = pat[7-i];
            expq  = {expq[6:0], pat[7-i]};
            tick();
            chk("ser_q", {24'd0, q}, {24'd0, expq});
            chk("ser_sout_l", {31'd0, sout_l}, {31'd0, expq[7]});
        end
        chk_state("ser_end", 8'hB2, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
